// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared types for the multiply/divide unit: the RISC-V M
//               funct3 operation encoding, the MDU control state encoding,
//               and small decode helpers on the operation code.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic op_is_div(input op_e op);
        return op[2];
    endfunction

    // Within the divide group, funct3[1] selects the remainder.
    function automatic logic op_is_rem(input op_e op);
        return op[2] & op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_cneg.sv
`default_nettype none
// ============================================================================
// Module      : rv_cneg
// Description : Conditional two's-complement negate. dout = neg ? -din : din.
// Ports       : neg  - negate request
//               din  - WIDTH-bit input value
//               dout - WIDTH-bit (possibly negated) output value
// Revision    : 1.0 - initial release
// ============================================================================
module rv_cneg #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + {{(WIDTH-1){1'b0}}, 1'b1}) : din;

endmodule
`default_nettype wire

// File: rtl/rv_mdu.sv
`default_nettype none
// ============================================================================
// Module      : rv_mdu
// Description : Multicycle RISC-V M-extension multiply/divide unit. Works on
//               operand magnitudes (radix-2 shift-add multiply, restoring
//               divide) and fixes the sign in a final cycle. Latency is a
//               fixed DPWIDTH+1 cycles from start to done.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               start, op       - request pulse and funct3 operation
//               opa, opb        - rs1/rs2 operands, sampled with start
//               busy, done      - in-progress flag, one-cycle completion pulse
//               result          - registered result, held until next completion
// Revision    : 1.0 - initial release
// ============================================================================
module rv_mdu
    import rv_pkg::*;
#(
    parameter int DPWIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [DPWIDTH-1:0] opa,
    input  logic [DPWIDTH-1:0] opb,
    output logic               busy,
    output logic               done,
    output logic [DPWIDTH-1:0] result
);

    localparam int                 CW    = $clog2(DPWIDTH);
    localparam logic [DPWIDTH-1:0] C_MIN = {1'b1, {(DPWIDTH-1){1'b0}}};
    localparam logic [CW-1:0]      C_CNT_LOAD = CW'(DPWIDTH-1);

    // ---------------- control FSM ----------------
    state_e r_state, w_state_next;
    logic   w_load, w_fix;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_fix        = 1'b0;
        case (r_state)
            ST_IDLE: if (start) begin
                w_load       = 1'b1;
                w_state_next = ST_CALC;
            end
            ST_CALC: if (r_cnt == '0) w_state_next = ST_FIX;
            ST_FIX: begin
                w_fix        = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- load-time decode ----------------
    op_e w_op;
    logic w_a_signed, w_b_signed, w_sa, w_sb, w_is_div, w_neg, w_dz, w_ovf;
    logic [DPWIDTH-1:0] w_a_mag, w_b_mag;

    assign w_op       = op_e'(op);
    assign w_a_signed = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                        (w_op == OP_DIV)  || (w_op == OP_REM);
    assign w_b_signed = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_sa       = w_a_signed & opa[DPWIDTH-1];
    assign w_sb       = w_b_signed & opb[DPWIDTH-1];
    assign w_is_div   = op_is_div(w_op);
    // Remainder takes the dividend's sign; product and quotient take the xor.
    assign w_neg      = op_is_rem(w_op) ? w_sa : (w_sa ^ w_sb);
    assign w_dz       = w_is_div && (opb == '0);
    assign w_ovf      = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                        (opa == C_MIN) && (opb == '1);

    rv_cneg #(.WIDTH(DPWIDTH)) u_abs_a (.neg(w_sa), .din(opa), .dout(w_a_mag));
    rv_cneg #(.WIDTH(DPWIDTH)) u_abs_b (.neg(w_sb), .din(opb), .dout(w_b_mag));

    // ---------------- datapath registers ----------------
    // r_acc is the product accumulator {hi, lo/multiplier} when multiplying
    // and the {remainder, quotient/dividend} pair when dividing.
    op_e                  r_op;
    logic [2*DPWIDTH-1:0] r_acc;
    logic [DPWIDTH-1:0]   r_opnd;   // multiplicand or divisor magnitude
    logic [DPWIDTH-1:0]   r_opa;    // raw rs1, returned as remainder on /0
    logic                 r_neg, r_dz, r_ovf, r_busy, r_done;
    logic [DPWIDTH-1:0]   r_result;

    logic [DPWIDTH:0] w_msum, w_dshift, w_ddiff;

    assign w_msum   = {1'b0, r_acc[2*DPWIDTH-1:DPWIDTH]} +
                      {1'b0, (r_acc[0] ? r_opnd : {DPWIDTH{1'b0}})};
    assign w_dshift = {r_acc[2*DPWIDTH-1:DPWIDTH], r_acc[DPWIDTH-1]};
    assign w_ddiff  = w_dshift - {1'b0, r_opnd};

    // ---------------- sign fix and output select ----------------
    logic [2*DPWIDTH-1:0] w_prod;
    logic [DPWIDTH-1:0]   w_div_mag, w_div_res, w_fix_res;

    assign w_div_mag = op_is_rem(r_op) ? r_acc[2*DPWIDTH-1:DPWIDTH] : r_acc[DPWIDTH-1:0];

    rv_cneg #(.WIDTH(2*DPWIDTH)) u_neg_prod (.neg(r_neg), .din(r_acc),     .dout(w_prod));
    rv_cneg #(.WIDTH(DPWIDTH))   u_neg_div  (.neg(r_neg), .din(w_div_mag), .dout(w_div_res));

    always_comb begin
        w_fix_res = w_div_res;
        case (r_op)
            OP_MUL:                       w_fix_res = w_prod[DPWIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[2*DPWIDTH-1:DPWIDTH];
            OP_DIV, OP_DIVU: begin
                if (r_dz)       w_fix_res = '1;
                else if (r_ovf) w_fix_res = C_MIN;
            end
            OP_REM, OP_REMU: begin
                if (r_dz)       w_fix_res = r_opa;
                else if (r_ovf) w_fix_res = '0;
            end
            default:            w_fix_res = w_div_res;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_MUL;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_opa    <= '0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= w_fix;
            if (w_load) begin
                r_op   <= w_op;
                r_acc  <= {{DPWIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                r_opnd <= w_is_div ? w_b_mag : w_a_mag;
                r_opa  <= opa;
                r_neg  <= w_neg;
                r_dz   <= w_dz;
                r_ovf  <= w_ovf;
                r_cnt  <= C_CNT_LOAD;
                r_busy <= 1'b1;
            end else if (r_state == ST_CALC) begin
                r_cnt <= r_cnt - CW'(1);
                if (!op_is_div(r_op)) begin
                    r_acc <= {w_msum, r_acc[DPWIDTH-1:1]};
                end else if (!w_ddiff[DPWIDTH]) begin
                    r_acc <= {w_ddiff[DPWIDTH-1:0], r_acc[DPWIDTH-2:0], 1'b1};
                end else begin
                    r_acc <= {w_dshift[DPWIDTH-1:0], r_acc[DPWIDTH-2:0], 1'b0};
                end
            end else if (w_fix) begin
                r_result <= w_fix_res;
                r_busy   <= 1'b0;
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_rv_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_mdu
// Description : Self-checking bench for rv_mdu (DPWIDTH=32). Directed cases
//               plus randomized operations compared against a 64-bit
//               arithmetic reference of the M-extension semantics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_mdu;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_errors = 0;

    rv_mdu #(.DPWIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: M-extension semantics via 64-bit / int arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        sa = a;
        sb = b;
        case (o)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b}; p = ea * eb; return p[63:32]; end
            3'd2: begin ea = {{32{a[31]}}, a}; eb = {32'b0, b};       p = ea * eb; return p[63:32]; end
            3'd3: begin ea = {32'b0, a};       eb = {32'b0, b};       p = ea * eb; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request so it is sampled at the next rising edge (T0);
    // returns #1 after T0 with start dropped and the operand bus scrambled.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        opa   = a;
        opb   = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 3'($urandom);
        opa   = $urandom;
        opb   = $urandom;
    endtask

    // Count edges after T0 (starting from 'already') until done, bounded.
    task automatic wait_done(input int already, input logic [31:0] exp, input string tag);
        int n;
        bit busy_ok;
        n       = already;
        busy_ok = 1'b1;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd33);
        check({tag, " result"}, result, exp);
        check({tag, " busy_low_at_done"}, {31'b0, busy}, 32'd0);
        check({tag, " busy_during_op"}, {31'b0, busy_ok}, 32'd1);
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        issue(o, a, b);
        wait_done(0, model(o, a, b), tag);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        opa   = '0;
        opb   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Latency and one-cycle done pulse.
        run(3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
        check("mul result const", result, 32'hFFFF_FFEB);
        @(posedge clk); #1;
        check("done pulse width", {31'b0, done}, 32'd0);
        check("result hold", result, 32'hFFFF_FFEB);

        // High halves, signed/unsigned divide, special cases.
        run(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
        check("mulh const", result, 32'h4000_0000);
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
        check("mulhu const", result, 32'hFFFF_FFFE);
        run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        check("mulhsu const", result, 32'hFFFF_FFFF);
        run(3'd4, 32'hFFFF_FFF9, 32'd2, "div");
        check("div const", result, 32'hFFFF_FFFD);
        run(3'd6, 32'hFFFF_FFF9, 32'd2, "rem");
        check("rem const", result, 32'hFFFF_FFFF);
        run(3'd5, 32'd7, 32'd2, "divu");
        check("divu const", result, 32'd3);
        run(3'd7, 32'd7, 32'd2, "remu");
        check("remu const", result, 32'd1);
        run(3'd4, 32'd5, 32'd0, "div_by_zero");
        check("div0 const", result, 32'hFFFF_FFFF);
        run(3'd6, 32'd5, 32'd0, "rem_by_zero");
        check("rem0 const", result, 32'd5);
        run(3'd4, 32'hFFFF_FFFB, 32'd0, "div_neg_by_zero");
        run(3'd7, 32'hFFFF_FFFB, 32'd0, "remu_by_zero");
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check("div ovf const", result, 32'h8000_0000);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        check("rem ovf const", result, 32'd0);

        // start during CALC is ignored.
        issue(3'd0, 32'd6, 32'd9);
        repeat (10) @(posedge clk);
        #1;
        op    = 3'd5;
        opa   = 32'd100;
        opb   = 32'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(11, 32'd54, "start_while_busy");

        // start in the done cycle is accepted back-to-back.
        issue(3'd5, 32'd1000, 32'd7);
        wait_done(0, 32'd142, "b2b first");
        issue(3'd7, 32'd1000, 32'd7);
        wait_done(0, 32'd6, "b2b second");

        // Reset in the middle of CALC.
        issue(3'd0, 32'd11, 32'd13);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst busy", {31'b0, busy}, 32'd0);
        check("midrst done", {31'b0, done}, 32'd0);
        check("midrst result", result, 32'd0);
        rst = 1'b0;
        run(3'd0, 32'd3, 32'd4, "mul_after_reset");
        check("mul after reset const", result, 32'd12);

        // Randomized operations against the reference.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            run(ro, ra, rb, $sformatf("rand%0d op%0d a=%h b=%h", i, ro, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
